// File: rtl/bp_seq_pkg.sv
// ----------------------------------------------------------------------------
// bp_seq_pkg
// Shared types for the back-propagation junction sequencer:
//   state_t  - sequencer FSM states
//   entry_t  - one in-flight datapath operation {valid, grp, final_pass}
// MAX_GW sets the widest partial-del group index an entry can carry. Each
// instance zero-extends its own GW-bit group into this field.
// ----------------------------------------------------------------------------
package bp_seq_pkg;

    localparam int MAX_GW = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic              valid;
        logic [MAX_GW-1:0] grp;
        logic              final_pass;  // last accumulation pass: result goes to delp
    } entry_t;

endpackage

// File: rtl/bp_inflight_tracker.sv
// ----------------------------------------------------------------------------
// bp_inflight_tracker
// LAT-deep shift register that follows each issued edge-group read through
// the datapath latency. The register shifts every cycle, so a cycle with no
// issue inserts a bubble (valid=0).
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   i_issue        a read is issued this cycle
//   i_grp          group of the read being issued / considered for issue
//   i_final        issued read belongs to the final pass
//   o_hazard       a valid entry in stages 1..LAT carries i_grp
//   o_pending      a valid entry sits in stages 1..LAT-1 (survives next shift)
//   o_wr_valid     stage-LAT entry is valid (datapath result available)
//   o_wr_final     stage-LAT entry belongs to the final pass
//   o_wr_grp       stage-LAT group address
// ----------------------------------------------------------------------------
module bp_inflight_tracker
    import bp_seq_pkg::*;
#(
    parameter int LAT = 5,
    parameter int GW  = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_issue,
    input  logic [GW-1:0] i_grp,
    input  logic          i_final,
    output logic          o_hazard,
    output logic          o_pending,
    output logic          o_wr_valid,
    output logic          o_wr_final,
    output logic [GW-1:0] o_wr_grp
);

    if (LAT < 1) begin : g_bad_lat
        $error("bp_inflight_tracker: LAT must be at least 1");
    end
    if (GW > MAX_GW) begin : g_bad_gw
        $error("bp_inflight_tracker: GW exceeds MAX_GW");
    end

    entry_t r_stage [1:LAT];
    entry_t w_new;

    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_new = '0;
        if (i_issue) begin
            w_new.valid      = 1'b1;
            w_new.grp        = MAX_GW'(i_grp);
            w_new.final_pass = i_final;
        end
    end

    // NOTE: the stages are control state (valid bits), not a data memory, so
    // they are reset; a stale valid would fire a spurious write after reset.
    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its neighbour's pre-edge value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 1; s <= LAT; s++) begin
                r_stage[s] <= '0;
            end
        end else begin
            r_stage[1] <= w_new;
            for (int s = 2; s <= LAT; s++) begin
                r_stage[s] <= r_stage[s-1];
            end
        end
    end

    // Stage LAT is included in the hazard compare: its write lands this cycle
    // and only becomes readable one cycle later.
    always_comb begin
        o_hazard  = 1'b0;
        o_pending = 1'b0;
        for (int s = 1; s <= LAT; s++) begin
            if (r_stage[s].valid && (r_stage[s].grp == MAX_GW'(i_grp))) begin
                o_hazard = 1'b1;
            end
        end
        for (int s = 1; s < LAT; s++) begin
            if (r_stage[s].valid) begin
                o_pending = 1'b1;
            end
        end
    end

    assign o_wr_valid = r_stage[LAT].valid;
    assign o_wr_final = r_stage[LAT].final_pass;
    assign o_wr_grp   = r_stage[LAT].grp[GW-1:0];

endmodule

// File: rtl/bp_junction_sequencer.sv
// ----------------------------------------------------------------------------
// bp_junction_sequencer
// Drives one back-propagation junction: issues CPC = P*FO/Z edge-group read
// cycles, tracks them through the LAT-cycle datapath, emits partial-del
// write-backs (non-final passes) and delp writes (final pass), blocks reads
// of a partial-del group that still has a write in flight, and pulses done.
// Issue k maps to group k%G and pass k/G via wrapping counters.
// Ports:
//   clk, reset              clock, asynchronous active-low reset
//   start                   one-cycle pulse, begins a run (ignored unless IDLE)
//   stall                   upstream memories not ready, suppresses issue
//   busy                    run in progress (RUN or DRAIN)
//   done                    one-cycle pulse after the last write-back
//   rd_en                   read issue strobe
//   wt_rd_addr, del_rd_addr issue index k (hold last value when idle)
//   pd_rd_addr              partial-del group read address (holds)
//   pd_first                issue belongs to pass 0 (partial del taken as 0)
//   pd_wr_en, delp_wr_en    write-back strobes for non-final / final pass
//   wr_addr                 group address for either write
// ----------------------------------------------------------------------------
module bp_junction_sequencer
    import bp_seq_pkg::*;
#(
    parameter  int Z   = 32,
    parameter  int FI  = 16,
    parameter  int FO  = 8,
    parameter  int P   = 64,
    parameter  int LAT = 5,
    localparam int CPC = P * FO / Z,
    localparam int G   = P / Z,
    localparam int AW  = (CPC > 1) ? $clog2(CPC) : 1,
    localparam int GW  = (G > 1) ? $clog2(G) : 1,
    localparam int PW  = (FO > 1) ? $clog2(FO) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stall,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] wt_rd_addr,
    output logic [AW-1:0] del_rd_addr,
    output logic [GW-1:0] pd_rd_addr,
    output logic          pd_first,
    output logic          pd_wr_en,
    output logic          delp_wr_en,
    output logic [GW-1:0] wr_addr
);

    if ((P % Z) != 0) begin : g_bad_p
        $error("bp_junction_sequencer: P must be a multiple of Z");
    end
    if ((Z % FI) != 0) begin : g_bad_fi
        $error("bp_junction_sequencer: Z must be a multiple of FI");
    end

    state_t        r_state;
    state_t        w_next_state;
    logic [AW-1:0] r_k;
    logic [GW-1:0] r_grp;
    logic [PW-1:0] r_pass;
    logic [AW-1:0] r_addr_hold;
    logic [GW-1:0] r_grp_hold;

    logic          w_issue;
    logic          w_last_issue;
    logic          w_final;
    logic          w_hazard;
    logic          w_pending;
    logic          w_wr_valid;
    logic          w_wr_final;
    logic [GW-1:0] w_wr_grp;

    assign w_final      = (r_pass == PW'(FO - 1));
    assign w_issue      = (r_state == RUN) && !stall && !w_hazard;
    assign w_last_issue = w_issue && (r_k == AW'(CPC - 1));

    bp_inflight_tracker #(
        .LAT (LAT),
        .GW  (GW)
    ) u_tracker (
        .clk        (clk),
        .reset      (reset),
        .i_issue    (w_issue),
        .i_grp      (r_grp),
        .i_final    (w_final),
        .o_hazard   (w_hazard),
        .o_pending  (w_pending),
        .o_wr_valid (w_wr_valid),
        .o_wr_final (w_wr_final),
        .o_wr_grp   (w_wr_grp)
    );

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM: next state. DRAIN ends when nothing remains in stages 1..LAT-1;
    // the stage-LAT entry writes back during that final DRAIN cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start)        w_next_state = RUN;
            RUN:     if (w_last_issue) w_next_state = DRAIN;
            DRAIN:   if (!w_pending)   w_next_state = DONE;
            DONE:                      w_next_state = IDLE;
            default:                   w_next_state = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (r_state == RUN) || (r_state == DRAIN);
        done = (r_state == DONE);
    end

    // Issue counters advance only on issue; group wrap bumps the pass.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_k         <= '0;
            r_grp       <= '0;
            r_pass      <= '0;
            r_addr_hold <= '0;
            r_grp_hold  <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_k    <= '0;
            r_grp  <= '0;
            r_pass <= '0;
        end else if (w_issue) begin
            r_k         <= r_k + 1'b1;
            r_addr_hold <= r_k;
            r_grp_hold  <= r_grp;
            if (r_grp == GW'(G - 1)) begin
                r_grp  <= '0;
                r_pass <= r_pass + 1'b1;
            end else begin
                r_grp <= r_grp + 1'b1;
            end
        end
    end

    assign rd_en       = w_issue;
    assign wt_rd_addr  = w_issue ? r_k : r_addr_hold;
    assign del_rd_addr = w_issue ? r_k : r_addr_hold;
    assign pd_rd_addr  = w_issue ? r_grp : r_grp_hold;
    assign pd_first    = w_issue && (r_pass == '0);

    assign pd_wr_en    = w_wr_valid && !w_wr_final;
    assign delp_wr_en  = w_wr_valid && w_wr_final;
    assign wr_addr     = w_wr_grp;

endmodule

// File: tb/tb_bp_junction_sequencer.sv
// ----------------------------------------------------------------------------
// tb_bp_junction_sequencer
// Three sequencer instances: default (G=2, FO=8), wide (P=256, G=8) and
// single-pass (FO=1). Each run records issue/write/done events by cycle
// number (cycle 0 = first RUN cycle) and compares them with expected event
// schedules computed here from the junction parameters.
// ----------------------------------------------------------------------------
module tb_bp_junction_sequencer;

    localparam int LAT = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // default instance: CPC=16, G=2
    logic       d_start, d_stall, d_busy, d_done, d_rd_en, d_pd_first, d_pd_wr_en, d_delp_wr_en;
    logic [3:0] d_wt_rd_addr, d_del_rd_addr;
    logic [0:0] d_pd_rd_addr, d_wr_addr;
    // wide instance: CPC=64, G=8
    logic       b_start, b_stall, b_busy, b_done, b_rd_en, b_pd_first, b_pd_wr_en, b_delp_wr_en;
    logic [5:0] b_wt_rd_addr, b_del_rd_addr;
    logic [2:0] b_pd_rd_addr, b_wr_addr;
    // single-pass instance: CPC=2, G=2
    logic       f_start, f_stall, f_busy, f_done, f_rd_en, f_pd_first, f_pd_wr_en, f_delp_wr_en;
    logic [0:0] f_wt_rd_addr, f_del_rd_addr;
    logic [0:0] f_pd_rd_addr, f_wr_addr;

    bp_junction_sequencer #(.Z(32), .FI(16), .FO(8), .P(64), .LAT(LAT)) u_def (
        .clk(clk), .reset(reset), .start(d_start), .stall(d_stall),
        .busy(d_busy), .done(d_done), .rd_en(d_rd_en),
        .wt_rd_addr(d_wt_rd_addr), .del_rd_addr(d_del_rd_addr),
        .pd_rd_addr(d_pd_rd_addr), .pd_first(d_pd_first),
        .pd_wr_en(d_pd_wr_en), .delp_wr_en(d_delp_wr_en), .wr_addr(d_wr_addr));

    bp_junction_sequencer #(.Z(32), .FI(16), .FO(8), .P(256), .LAT(LAT)) u_big (
        .clk(clk), .reset(reset), .start(b_start), .stall(b_stall),
        .busy(b_busy), .done(b_done), .rd_en(b_rd_en),
        .wt_rd_addr(b_wt_rd_addr), .del_rd_addr(b_del_rd_addr),
        .pd_rd_addr(b_pd_rd_addr), .pd_first(b_pd_first),
        .pd_wr_en(b_pd_wr_en), .delp_wr_en(b_delp_wr_en), .wr_addr(b_wr_addr));

    bp_junction_sequencer #(.Z(32), .FI(16), .FO(1), .P(64), .LAT(LAT)) u_fo1 (
        .clk(clk), .reset(reset), .start(f_start), .stall(f_stall),
        .busy(f_busy), .done(f_done), .rd_en(f_rd_en),
        .wt_rd_addr(f_wt_rd_addr), .del_rd_addr(f_del_rd_addr),
        .pd_rd_addr(f_pd_rd_addr), .pd_first(f_pd_first),
        .pd_wr_en(f_pd_wr_en), .delp_wr_en(f_delp_wr_en), .wr_addr(f_wr_addr));

    typedef struct {
        int busy, done, rd_en, wt, del, pdr, first, pdw, dlp, wra;
    } smp_t;

    int n_checks = 0;
    int n_errors = 0;

    // recorded events of the current run
    int iss_cyc[$], iss_wt[$], iss_del[$], iss_pdr[$], iss_first[$];
    int wr_cyc[$], wr_adr[$], wr_fin[$];
    int done_cyc[$];
    int first_cnt, busy0, done_busy, last_wt, last_pdr, extra;
    int exp_iss[$];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic smp_t sample(input int sel);
        smp_t s;
        case (sel)
            0: s = '{int'(d_busy), int'(d_done), int'(d_rd_en), int'(d_wt_rd_addr), int'(d_del_rd_addr),
                     int'(d_pd_rd_addr), int'(d_pd_first), int'(d_pd_wr_en), int'(d_delp_wr_en), int'(d_wr_addr)};
            1: s = '{int'(b_busy), int'(b_done), int'(b_rd_en), int'(b_wt_rd_addr), int'(b_del_rd_addr),
                     int'(b_pd_rd_addr), int'(b_pd_first), int'(b_pd_wr_en), int'(b_delp_wr_en), int'(b_wr_addr)};
            default: s = '{int'(f_busy), int'(f_done), int'(f_rd_en), int'(f_wt_rd_addr), int'(f_del_rd_addr),
                     int'(f_pd_rd_addr), int'(f_pd_first), int'(f_pd_wr_en), int'(f_delp_wr_en), int'(f_wr_addr)};
        endcase
        return s;
    endfunction

    task automatic set_start(input int sel, input logic v);
        case (sel)
            0:       d_start = v;
            1:       b_start = v;
            default: f_start = v;
        endcase
    endtask

    task automatic set_stall(input int sel, input logic v);
        case (sel)
            0:       d_stall = v;
            1:       b_stall = v;
            default: f_stall = v;
        endcase
    endtask

    task automatic check_all_zero(input string tag, input int sel);
        smp_t s;
        s = sample(sel);
        check({tag, ":busy"}, s.busy, 0);
        check({tag, ":done"}, s.done, 0);
        check({tag, ":rd_en"}, s.rd_en, 0);
        check({tag, ":wt_addr"}, s.wt, 0);
        check({tag, ":del_addr"}, s.del, 0);
        check({tag, ":pd_rd_addr"}, s.pdr, 0);
        check({tag, ":pd_first"}, s.first, 0);
        check({tag, ":pd_wr_en"}, s.pdw, 0);
        check({tag, ":delp_wr_en"}, s.dlp, 0);
        check({tag, ":wr_addr"}, s.wra, 0);
    endtask

    // Pulse start, then record one cycle per iteration until done (bounded).
    task automatic run(input string name, input int sel, input int stall_lo,
                       input int stall_hi, input int restart_at);
        smp_t s;
        int   c;
        bit   seen_done;
        iss_cyc.delete(); iss_wt.delete(); iss_del.delete(); iss_pdr.delete(); iss_first.delete();
        wr_cyc.delete(); wr_adr.delete(); wr_fin.delete(); done_cyc.delete();
        first_cnt = 0; busy0 = 0; done_busy = -1; last_wt = -1; last_pdr = -1; extra = 0;
        @(negedge clk);
        set_start(sel, 1'b1);
        @(posedge clk);
        #1;
        set_start(sel, 1'b0);
        seen_done = 1'b0;
        c = 0;
        while (!seen_done && c < 300) begin
            set_stall(sel, (c >= stall_lo) && (c <= stall_hi));
            set_start(sel, c == restart_at);
            @(negedge clk);
            s = sample(sel);
            if (c == 0) busy0 = s.busy;
            if (s.rd_en != 0) begin
                iss_cyc.push_back(c); iss_wt.push_back(s.wt); iss_del.push_back(s.del);
                iss_pdr.push_back(s.pdr); iss_first.push_back(s.first);
            end
            if (s.first != 0) first_cnt++;
            if (s.pdw != 0 || s.dlp != 0) begin
                wr_cyc.push_back(c);
                wr_adr.push_back(s.wra);
                wr_fin.push_back((s.pdw != 0 && s.dlp != 0) ? 2 : s.dlp);
            end
            if (s.done != 0) begin
                done_cyc.push_back(c);
                done_busy = s.busy; last_wt = s.wt; last_pdr = s.pdr;
                seen_done = 1'b1;
            end
            @(posedge clk);
            #1;
            c++;
        end
        set_stall(sel, 1'b0);
        set_start(sel, 1'b0);
        check({name, ":done_seen"}, int'(seen_done), 1);
        repeat (4) begin
            @(negedge clk);
            s = sample(sel);
            extra += s.done + s.rd_en + s.busy + s.pdw + s.dlp;
        end
        check({name, ":quiet_after_done"}, extra, 0);
    endtask

    // Compare recorded events against exp_iss and the junction geometry.
    task automatic verify(input string name, input int g, input int cpc, input int fo);
        int n;
        check({name, ":busy_c0"}, busy0, 1);
        check({name, ":n_issue"}, iss_cyc.size(), cpc);
        n = (iss_cyc.size() < cpc) ? iss_cyc.size() : cpc;
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s:iss_cyc[%0d]", name, k), iss_cyc[k], exp_iss[k]);
            check($sformatf("%s:wt_addr[%0d]", name, k), iss_wt[k], k);
            check($sformatf("%s:del_addr[%0d]", name, k), iss_del[k], k);
            check($sformatf("%s:pd_rd_addr[%0d]", name, k), iss_pdr[k], k % g);
            check($sformatf("%s:pd_first[%0d]", name, k), iss_first[k], (k < g) ? 1 : 0);
        end
        check({name, ":pd_first_count"}, first_cnt, g);
        check({name, ":n_write"}, wr_cyc.size(), cpc);
        n = (wr_cyc.size() < cpc) ? wr_cyc.size() : cpc;
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s:wr_cyc[%0d]", name, k), wr_cyc[k], exp_iss[k] + LAT);
            check($sformatf("%s:wr_addr[%0d]", name, k), wr_adr[k], k % g);
            check($sformatf("%s:wr_is_delp[%0d]", name, k), wr_fin[k], ((k / g) == fo - 1) ? 1 : 0);
        end
        check({name, ":n_done"}, done_cyc.size(), 1);
        if (done_cyc.size() > 0) begin
            check({name, ":done_cyc"}, done_cyc[0], exp_iss[cpc-1] + LAT + 1);
        end
        check({name, ":busy_at_done"}, done_busy, 0);
        check({name, ":wt_addr_hold"}, last_wt, cpc - 1);
        check({name, ":pd_rd_addr_hold"}, last_pdr, (cpc - 1) % g);
    endtask

    initial begin
        smp_t s;
        reset = 1'b0;
        d_start = 1'b0; d_stall = 1'b0;
        b_start = 1'b0; b_stall = 1'b0;
        f_start = 1'b0; f_stall = 1'b0;

        // reset state of all three instances
        repeat (2) @(negedge clk);
        check_all_zero("rst_def", 0);
        check_all_zero("rst_big", 1);
        check_all_zero("rst_fo1", 2);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // reset mid-run: asserted during cycle 3, outputs clear immediately
        d_start = 1'b1;
        @(posedge clk);
        #1;
        d_start = 1'b0;
        @(negedge clk);
        s = sample(0);
        check("midrst:rd_en_c0", s.rd_en, 1);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_all_zero("midrst", 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        s = sample(0);
        check("midrst:idle_busy", s.busy, 0);
        check("midrst:idle_done", s.done, 0);

        // default geometry: pairs of issues every LAT+1 cycles
        exp_iss.delete();
        for (int k = 0; k < 16; k++) exp_iss.push_back(6 * (k / 2) + (k % 2));
        run("def", 0, -1, -1, -1);
        verify("def", 2, 16, 8);

        // start pulsed at cycle 5 during the run is ignored
        run("restart", 0, -1, -1, 5);
        verify("restart", 2, 16, 8);

        // G=8: no hazard bubbles, back-to-back issues
        exp_iss.delete();
        for (int k = 0; k < 64; k++) exp_iss.push_back(k);
        run("g8", 1, -1, -1, -1);
        verify("g8", 8, 64, 8);

        // G=8 with stall at cycles 10..12: later events shift by 3
        exp_iss.delete();
        for (int k = 0; k < 64; k++) exp_iss.push_back((k < 10) ? k : k + 3);
        run("stall", 1, 10, 12, -1);
        verify("stall", 8, 64, 8);

        // FO=1: single pass, every write goes to delp
        exp_iss.delete();
        for (int k = 0; k < 2; k++) exp_iss.push_back(k);
        run("fo1", 2, -1, -1, -1);
        verify("fo1", 2, 2, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bp_junction_sequencer.md
Name: bp_junction_sequencer

Overview:
- Controller that drives one back-propagation junction: the z-wide BP processor set plus its weight, deln, adot and partial-del memories.
- Per junction run, it issues cpc = P*FO/Z edge-group read cycles and tracks each one through the datapath latency.
- It generates partial-del write-back and final delp writes.
- It interlocks read-after-write hazards on the partial-del memory and reports completion.

Parameters:
- Z, 32, edges processed per cycle
- FI, 16, fan-in of next-layer neurons
- FO, 8, fan-out of previous-layer neurons; equals the number of accumulation passes
- P, 64, previous-layer neurons; P%Z==0
- LAT, 5, cycles from issue to datapath result (del_out valid); LAT>=1
- Derived localparams: CPC=P*FO/Z, G=P/Z (partial-del groups), AW=clog2(CPC), GW=max(1,clog2(G))

Ports:
- clk in 1 system clock
- reset in 1 asynchronous, active-low (0 = reset)
- start in 1 one-cycle pulse; begin junction run
- stall in 1 upstream memories not ready; suppresses issue this cycle
- busy out 1 run in progress
- done out 1 one-cycle pulse after last write-back
- rd_en out 1 issue strobe for wt/del_in/adot/partial-del reads
- wt_rd_addr out AW weight word index (= issue count)
- del_rd_addr out AW deln word index (= issue count; Z/FI deln values per word)
- pd_rd_addr out GW partial-del group read address
- pd_first out 1 issued cycle is pass 0; datapath uses 0 for partial del
- pd_wr_en out 1 write datapath result back to partial-del memory (non-final pass)
- delp_wr_en out 1 write datapath result to delp memory (final pass)
- wr_addr out GW group address for either write

Behaviour:
- Reset (async, reset==0) state: FSM=IDLE, counters 0, valid pipeline cleared; all outputs 0.
- FSM IDLE -> RUN on start. RUN -> DRAIN when issue count reaches CPC. DRAIN -> DONE when pipeline empty. DONE -> IDLE after 1 cycle.
- busy=1 in RUN and DRAIN. done=1 in DONE only.
- start while busy or DONE is ignored.
- Cycle 0 is the first RUN cycle (the cycle after start is sampled).
- Issue index k (0..CPC-1): group g=k%G, pass j=k/G. Use separate group/pass counters, no divider.
- Outputs on issue: rd_en=1, wt_rd_addr=del_rd_addr=k, pd_rd_addr=g, pd_first=(j==0).
- Address outputs hold their last value when rd_en=0. pd_first=0 when rd_en=0.
- Issue is allowed only when all of the following hold:
  - state RUN
  - stall==0
  - no hazard: no valid in-flight entry in pipeline stages 1..LAT carries group g
- Pipeline tracking: LAT-deep shift register of {valid, g, final=(j==FO-1)}. It shifts every cycle and ignores stall, so bubbles enter as valid=0.
- Write-back: the entry at stage LAT drives the write outputs that cycle.
  - wr_addr=g.
  - pd_wr_en=valid&!final; delp_wr_en=valid&final.
  - A write in cycle c is visible to a read issued in cycle c+1.
- The hazard check includes stage LAT, so a read never issues in the same cycle as a write to its group.
- Issue count, group and pass counters advance only on issue. Group wraps G-1 -> 0 and increments pass.
- Stall in DRAIN has no effect.
- Reset mid-run aborts immediately. No done pulse. Partial memory contents are undefined; the next start restarts from k=0.
- FO==1: every write is delp_wr_en and pd_first=1 on all issues.

Decomposition:
- Package bp_seq_pkg: FSM state enum (IDLE, RUN, DRAIN, DONE) and the in-flight entry struct {valid, grp, final}.
- Sub-module bp_inflight_tracker: LAT-deep shift register plus parallel group-match compare, outputs hazard and the stage-LAT entry.
- Top module holds the FSM, counters and address generation.

Test Plan:
- Reset mid-run (reset=0 at cycle 3) -> all outputs 0 within the same cycle, busy=0. A following start runs a complete sequence from k=0.
- Defaults (G=2, LAT=5), start, no stall:
  - issues at cycles 0,1, 6,7, 12,13, ..., 42,43 (hazard period LAT+1).
  - pd_first only at cycles 0,1.
  - pd_wr_en at 5,6, 11,12, ...; delp_wr_en at 47,48 (wr_addr 0,1).
  - done at cycle 49.
- P=256 (G=8), LAT=5, no stall:
  - 64 consecutive issues, cycles 0..63, no hazard bubbles.
  - delp_wr_en at cycles 61..68, wr_addr 0..7.
  - done at 69.
- P=256, stall high at cycles 10..12 -> issues k=10..12 land at cycles 13..15. Every later event shifts by 3; done at 72.
- start pulsed at cycle 5 during a run -> ignored; run completes with exactly CPC issues and one done pulse.
- FO=1, P=64, LAT=5 -> issues at 0,1; delp_wr_en at 5,6; pd_wr_en never asserted; done at 7.
